// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with a small prefetch queue.
// Keeps at most one instruction-memory request in flight (IDLE/WAIT/DROP),
// buffers returned words with their next-PC, and flushes on redirect.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to hand an acked word
// straight to the consumer when the queue is empty (saves one cycle).
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc_4
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             state_reg;
    logic [31:0]        fetch_pc_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_next;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic [31:0]        out_inst_reg;
    logic [31:0]        out_pc_4_reg;

    logic [31:0]        inst_mem [DEPTH];
    logic [31:0]        pc4_mem  [DEPTH];

    logic               issue;
    logic               word_ok;
    logic               bypass_hit;
    logic               push;
    logic               pop;
    logic               head_from_push;

    // Handshake decode: issue, accepted response, bypass, push/pop and next count
    always_comb begin
        issue    = (state_reg == IDLE) && !redirect && (count_reg < CNT_W'(DEPTH));
        word_ok  = (state_reg == WAIT) && imem_ack && !redirect;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_hit = word_ok && (count_reg == '0);
`else
        bypass_hit = 1'b0;
`endif
        // A bypassed word that is consumed immediately never enters the queue
        push = word_ok && !(bypass_hit && out_ready);
        pop  = (count_reg != '0) && out_ready && !redirect;

        count_next = count_reg;
        if (redirect) begin
            count_next = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end

        rd_ptr_next = pop ? (rd_ptr_reg + PTR_W'(1)) : rd_ptr_reg;

        // The new head is the word being written only when the queue drains to
        // empty (or already is) in this same cycle
        head_from_push = push && ((count_reg == '0) ||
                                  ((count_reg == CNT_W'(1)) && pop));
    end

    // Request and consumer-side outputs; the pushed next-PC is fetch_pc_reg,
    // which already holds request address + 4 while in WAIT
    always_comb begin
        imem_req  = issue;
        imem_addr = fetch_pc_reg;
        out_valid = (count_reg != '0) || bypass_hit;
        out_inst  = bypass_hit ? imem_data    : out_inst_reg;
        out_pc_4  = bypass_hit ? fetch_pc_reg : out_pc_4_reg;
    end

    // Fetch FSM: one outstanding request, redirect always wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc_reg <= redirect_pc;
                    end else if (issue) begin
                        fetch_pc_reg <= fetch_pc_reg + 32'd4;
                        state_reg    <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        fetch_pc_reg <= redirect_pc;
                        state_reg    <= imem_ack ? IDLE : DROP;
                    end else if (imem_ack) begin
                        state_reg <= IDLE;
                    end
                end
                DROP: begin
                    if (redirect) begin
                        fetch_pc_reg <= redirect_pc;
                    end else if (imem_ack) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Queue bookkeeping and registered head outputs (loaded with the next head)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            out_inst_reg <= 32'h0;
            out_pc_4_reg <= 32'h0;
        end else if (redirect) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            count_reg  <= count_next;
            rd_ptr_reg <= rd_ptr_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (count_next != '0) begin
                out_inst_reg <= head_from_push ? imem_data    : inst_mem[rd_ptr_next];
                out_pc_4_reg <= head_from_push ? fetch_pc_reg : pc4_mem[rd_ptr_next];
            end
        end
    end

    // Queue storage; no reset so it maps onto plain RAM
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_reg] <= imem_data;
            pc4_mem[wr_ptr_reg]  <= fetch_pc_reg;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue. Expected {inst, pc+4}
// pairs are queued when a request issues and compared when the DUT hands a
// word to the consumer; redirects flush the expected queue.
module tb_fetch_queue;

    localparam logic [31:0] TB_RESET_PC = 32'h0;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc_4;

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (TB_RESET_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc_4    (out_pc_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] sb[$];
    logic [31:0] issue_log[$];
    logic [31:0] pop_log[$];

    // memory model and stimulus controls
    int          mem_lat = 1;
    bit          mem_pending = 0;
    int          mem_wait = 0;
    logic [31:0] mem_addr = 32'h0;
    bit          drv_redirect = 0;
    logic [31:0] drv_redirect_pc = 32'h0;
    bit          drv_ready = 0;
    bit          ready_on_ack = 0;
    int          ack_count = 0;
    int          pop_count = 0;

    // values seen in the most recent cycle
    logic        obs_valid;
    logic        obs_req;
    logic [31:0] obs_addr;
    logic [31:0] obs_inst;
    logic [31:0] obs_pc4;
    logic        obs_ack;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    // One clock cycle: drive at negedge, observe 1ns later, then pass the posedge
    task automatic cycle();
        logic [63:0] exp;
        @(negedge clk);
        imem_ack = 1'b0;
        if (mem_pending) begin
            if (mem_wait == 0) begin
                imem_ack    = 1'b1;
                imem_data   = inst_of(mem_addr);
                mem_pending = 0;
            end else begin
                mem_wait--;
            end
        end
        redirect    = drv_redirect;
        redirect_pc = drv_redirect_pc;
        out_ready   = ready_on_ack ? imem_ack : drv_ready;
        #1;
        obs_valid = out_valid;
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_inst  = out_inst;
        obs_pc4   = out_pc_4;
        obs_ack   = imem_ack;
        if (redirect) sb.delete();
        if (imem_req) begin
            n_vec++;
            if (mem_pending || imem_ack || redirect) begin
                n_err++;
                $display("FAIL req_overlap: imem_req=1 with pending=%0d ack=%0d redirect=%0d, required no request",
                         mem_pending, imem_ack, redirect);
            end
            mem_pending = 1;
            mem_wait    = mem_lat - 1;
            mem_addr    = imem_addr;
            issue_log.push_back(imem_addr);
            sb.push_back({inst_of(imem_addr), imem_addr + 32'd4});
            $display("  req  addr=%08h", imem_addr);
        end
        if (imem_ack && !redirect) ack_count++;
        if (out_valid && out_ready && !redirect) begin
            n_vec++;
            pop_count++;
            pop_log.push_back(out_pc_4);
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL pop_unexpected: got inst=%08h pc4=%08h, required no output", out_inst, out_pc_4);
            end else begin
                exp = sb.pop_front();
                if (out_inst !== exp[63:32] || out_pc_4 !== exp[31:0]) begin
                    n_err++;
                    $display("FAIL pop_data: got inst=%08h pc4=%08h, required inst=%08h pc4=%08h",
                             out_inst, out_pc_4, exp[63:32], exp[31:0]);
                end else begin
                    $display("  pop  inst=%08h pc4=%08h", out_inst, out_pc_4);
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n        = 1'b0;
        drv_redirect = 0;
        drv_ready    = 0;
        ready_on_ack = 0;
        redirect     = 1'b0;
        imem_ack     = 1'b0;
        out_ready    = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_pc_4 !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset: valid=%0b inst=%08h pc4=%08h, required 0/0/0", out_valid, out_inst, out_pc_4);
        end
        sb.delete();
        issue_log.delete();
        pop_log.delete();
        mem_pending = 0;
        ack_count   = 0;
        pop_count   = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_data = 32'h0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_pc_4 !== 32'h0 || imem_addr !== TB_RESET_PC) begin
            n_err++;
            $display("FAIL reset_state: valid=%0b inst=%08h pc4=%08h addr=%08h, required 0/0/0/%08h",
                     out_valid, out_inst, out_pc_4, imem_addr, TB_RESET_PC);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mem_lat = 1;
        cycle();
        n_vec++;
        if (obs_req !== 1'b1 || obs_addr !== TB_RESET_PC) begin
            n_err++;
            $display("FAIL first_request: req=%0b addr=%08h, required 1/%08h", obs_req, obs_addr, TB_RESET_PC);
        end
    endtask

    task automatic test_basic();
        logic [31:0] exp_a;
        reset_dut();
        mem_lat   = 1;
        drv_ready = 1;
        run(12);
        for (int i = 0; i < 3; i++) begin
            exp_a = 32'(i * 4);
            n_vec++;
            if (issue_log.size() <= i || issue_log[i] !== exp_a) begin
                n_err++;
                $display("FAIL basic_addr%0d: got %08h, required %08h", i,
                         (issue_log.size() > i) ? issue_log[i] : 32'hx, exp_a);
            end
            n_vec++;
            if (pop_log.size() <= i || pop_log[i] !== exp_a + 32'd4) begin
                n_err++;
                $display("FAIL basic_pc4_%0d: got %08h, required %08h", i,
                         (pop_log.size() > i) ? pop_log[i] : 32'hx, exp_a + 32'd4);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_p;
        reset_dut();
        mem_lat   = 1;
        drv_ready = 0;
        run(8);
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_vec++;
            if (obs_req !== 1'b0 || obs_valid !== 1'b1 || obs_pc4 !== 32'h4) begin
                n_err++;
                $display("FAIL stall_full: req=%0b valid=%0b pc4=%08h, required 0/1/00000004",
                         obs_req, obs_valid, obs_pc4);
            end
        end
        n_vec++;
        if (ack_count !== 4) begin
            n_err++;
            $display("FAIL stall_pushes: got %0d words, required 4", ack_count);
        end
        issue_log.delete();
        pop_log.delete();
        drv_ready = 1;
        run(12);
        for (int i = 0; i < 4; i++) begin
            exp_p = 32'((i + 1) * 4);
            n_vec++;
            if (pop_log.size() <= i || pop_log[i] !== exp_p) begin
                n_err++;
                $display("FAIL drain_%0d: got %08h, required %08h", i,
                         (pop_log.size() > i) ? pop_log[i] : 32'hx, exp_p);
            end
        end
        n_vec++;
        if (issue_log.size() == 0 || issue_log[0] !== 32'h10) begin
            n_err++;
            $display("FAIL resume_addr: got %08h, required 00000010",
                     (issue_log.size() > 0) ? issue_log[0] : 32'hx);
        end
    endtask

    task automatic test_redirect_wait();
        reset_dut();
        mem_lat   = 4;
        drv_ready = 1;
        cycle();
        drv_redirect    = 1;
        drv_redirect_pc = 32'h100;
        cycle();
        drv_redirect = 0;
        issue_log.delete();
        pop_log.delete();
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_vec++;
            if (obs_req !== 1'b0 || obs_valid !== 1'b0) begin
                n_err++;
                $display("FAIL drop_quiet%0d: req=%0b valid=%0b, required 0/0", i, obs_req, obs_valid);
            end
        end
        mem_lat = 1;
        run(8);
        n_vec++;
        if (issue_log.size() == 0 || issue_log[0] !== 32'h100) begin
            n_err++;
            $display("FAIL redirect_addr: got %08h, required 00000100",
                     (issue_log.size() > 0) ? issue_log[0] : 32'hx);
        end
        n_vec++;
        if (pop_log.size() == 0 || pop_log[0] !== 32'h104) begin
            n_err++;
            $display("FAIL redirect_pc4: got %08h, required 00000104",
                     (pop_log.size() > 0) ? pop_log[0] : 32'hx);
        end
    endtask

    task automatic test_redirect_ack();
        reset_dut();
        mem_lat   = 1;
        drv_ready = 0;
        run(5);
        drv_redirect    = 1;
        drv_redirect_pc = 32'h200;
        cycle();
        drv_redirect = 0;
        n_vec++;
        if (obs_ack !== 1'b1 || obs_valid !== 1'b1) begin
            n_err++;
            $display("FAIL redir_ack_setup: ack=%0b valid=%0b, required 1/1", obs_ack, obs_valid);
        end
        pop_log.delete();
        cycle();
        n_vec++;
        if (obs_valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h200) begin
            n_err++;
            $display("FAIL redir_ack_after: valid=%0b req=%0b addr=%08h, required 0/1/00000200",
                     obs_valid, obs_req, obs_addr);
        end
        drv_ready = 1;
        run(6);
        n_vec++;
        if (pop_log.size() == 0 || pop_log[0] !== 32'h204) begin
            n_err++;
            $display("FAIL redir_ack_pc4: got %08h, required 00000204",
                     (pop_log.size() > 0) ? pop_log[0] : 32'hx);
        end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        mem_lat   = 1;
        drv_ready = 0;
        run(4);
        ready_on_ack = 1;
        pop_count    = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            n_vec++;
            if (obs_valid !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_valid%0d: got %0b, required 1", i, obs_valid);
            end
        end
        n_vec++;
        if (pop_count !== 10) begin
            n_err++;
            $display("FAIL b2b_pops: got %0d, required 10", pop_count);
        end
        // starve the memory and drain: exactly the two held entries remain
        ready_on_ack = 0;
        mem_lat      = 50;
        drv_ready    = 1;
        pop_count    = 0;
        run(6);
        n_vec++;
        if (pop_count !== 2) begin
            n_err++;
            $display("FAIL b2b_residue: got %0d entries, required 2", pop_count);
        end
    endtask

    task automatic test_bypass();
        reset_dut();
        mem_lat   = 2;
        drv_ready = 1;
        run(2);
        cycle();
`ifdef FETCH_QUEUE_BYPASS_EN
        n_vec++;
        if (obs_ack !== 1'b1 || obs_valid !== 1'b1 || obs_inst !== inst_of(32'h0)) begin
            n_err++;
            $display("FAIL bypass_same: ack=%0b valid=%0b inst=%08h, required 1/1/%08h",
                     obs_ack, obs_valid, obs_inst, inst_of(32'h0));
        end
        cycle();
        n_vec++;
        if (obs_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bypass_after: valid=%0b, required 0", obs_valid);
        end
`else
        n_vec++;
        if (obs_ack !== 1'b1 || obs_valid !== 1'b0) begin
            n_err++;
            $display("FAIL nobypass_same: ack=%0b valid=%0b, required 1/0", obs_ack, obs_valid);
        end
        cycle();
        n_vec++;
        if (obs_valid !== 1'b1 || obs_pc4 !== 32'h4) begin
            n_err++;
            $display("FAIL nobypass_after: valid=%0b pc4=%08h, required 1/00000004", obs_valid, obs_pc4);
        end
`endif
        run(4);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_ack();
        test_back_to_back();
        test_bypass();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
